mm_engine: RTL and testbench
============================

Name: mm_engine

Overview:
Parametrised signed matrix-multiply engine computing C = A x B, or C = A x B^T in transpose mode, from operands held in an external word-addressed memory.
- Successor to the fixed 20-bit multiplier block. Adds generic widths, a start/busy control pair, and variable-latency read/write handshakes.
- Also adds dimension checking with an error flag, optional output saturation, and a sticky overflow flag.
- Sits between the test/system memory model and the controller that launches jobs.

Parameters:
DW, 20, signed operand width (read_data).
OW, 40, signed result width (write_data).
IW, 8, index width of i/j; max dimension MAX_DIM = 2**IW - 1.

Ports:
clk  in  1  clock, all logic on rising edge.
reset  in  1  synchronous, active-high.
start  in  1  launch job; sampled only in IDLE.
mode_tb  in  1  1: B is stored transposed (B[c][k] at i=c, j=k); latched at start.
sat_en  in  1  1: saturate results to OW signed range, 0: wrap (low OW bits); latched at start.
read  out  1  read request.
write  out  1  write request.
sel  out  2  region: 00 size, 01 A, 10 B, 11 C.
i  out  IW  row address.
j  out  IW  column address.
read_data  in  DW  signed data, valid when read_valid=1.
read_valid  in  1  read completion; may be high in the same cycle as read.
write_ready  in  1  write accepted.
write_data  out  OW  signed result element.
busy  out  1  high from start acceptance until DONE/ERR.
finish  out  1  high in DONE, held until next accepted start.
err  out  1  high in ERR, held until next accepted start.
ovf  out  1  sticky: any result clipped (sat_en=1) or wrapped (sat_en=0) in the current job.

Behaviour:
- Reset, synchronous and active-high: state IDLE; read, write, busy, finish, err and ovf = 0; i, j, sel = 0; write_data = 0; accumulator = 0. Reset asserted mid-job aborts the job; no further requests are issued after that edge.
- States: IDLE, SIZE, READ_A, READ_B, WRITE, DONE, ERR.
- IDLE:
  - start=1 latches mode_tb and sat_en, clears finish, err and ovf, sets busy, and moves to SIZE.
  - start is ignored outside IDLE, DONE and ERR.
  - DONE and ERR accept start exactly as IDLE does.
- Read handshake: read=1 with sel, i and j held stable until the cycle read_valid=1. Data is captured on that edge and the next request is issued the following cycle. Minimum cost is 1 cycle per read.
- SIZE: four reads at sel=00, j=0, i=0..3, giving RA, CA, RB, CB (low IW bits after a range check).
  - Transpose mode: the third and fourth words are CB and RB respectively, i.e. B is CB x RB in storage.
  - After the fourth read: ERR if any size is 0, any size exceeds MAX_DIM, or CA != RB. Otherwise go to READ_A with r=c=k=0 and acc=0.
- READ_A: read A[r][k] (sel=01, i=r, j=k) into the hold register, then go to READ_B.
- READ_B: read B[k][c] (sel=10, i=k, j=c), or B[c][k] (i=c, j=k) if mode_tb.
  - On the capture edge: acc += sext(a) * sext(b), with exact 2*DW-bit product and accumulator width 2*DW+IW (no internal overflow).
  - If k == CA-1, go to WRITE; otherwise k++ and go to READ_A.
- WRITE: write=1, sel=11, i=r, j=c, write_data = convert(acc), all held until write_ready=1.
  - convert: if acc lies outside [-2^(OW-1), 2^(OW-1)-1], set ovf; output the clamped value if sat_en, else the low OW bits.
  - On acceptance: acc=0, k=0.
  - If c == CB-1 and r == RA-1, go to DONE. Else if c == CB-1, then r++, c=0, next READ_A. Else c++, next READ_A.
- Result order is row-major over C. Exactly RA*CB writes, each element written exactly once.
- DONE: busy=0, finish=1, read=write=0. ERR: busy=0, err=1, read=write=0, no C writes issued.
- read and write are never high in the same cycle.

Test Plan:
- Zero-wait memory (read_valid=write_ready=1), DW=20, OW=40: sizes 2,2,2,2; A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> writes (0,0)=19, (0,1)=22, (1,0)=43, (1,1)=50 in that order; finish after exactly 4+4*4+4 request cycles.
- Negatives and non-square: A 1x3=[-1,2,-3], B 3x2=[[4,0],[-5,1],[6,-2]] -> C=[-32,8]; ovf=0.
- Transpose mode: same A/B as the first scenario with B stored transposed, mode_tb=1 -> identical C; B read addresses are (c,k).
- DW=8, OW=16: A 1x4 all 127, B 4x1 all 127 -> sat_en=1 writes 32767 and ovf=1; sat_en=0 writes 16'hFC04 and ovf=1.
- Sizes 2,3,2,2 (CA != RB), and separately RA=0 -> err=1, busy=0, no write pulses; a new start then runs the first scenario correctly.
- Random 0-3 cycle read_valid/write_ready delays, then reset asserted during the second WRITE -> request outputs stay stable while waiting; next edge after reset: all outputs 0, state IDLE, and no requests until start.

Source files
------------

// File: rtl/mm_engine.sv
// mm_engine: signed matrix-multiply engine computing C = A x B, or C = A x B^T
// when B is stored transposed, with operands and results in an external
// word-addressed memory reached through read/write handshakes.
module mm_engine #(
  parameter int DW = 20,
  parameter int OW = 40,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode_tb,
  input  logic          sat_en,
  output logic          read,
  output logic          write,
  output logic [1:0]    sel,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j,
  input  logic [DW-1:0] read_data,
  input  logic          read_valid,
  input  logic          write_ready,
  output logic [OW-1:0] write_data,
  output logic          busy,
  output logic          finish,
  output logic          err,
  output logic          ovf
);

  // Accumulator is wide enough that MAX_DIM full-scale products never overflow.
  localparam int AW = 2 * DW + IW;
  localparam logic signed [63:0] MAX_DIM = (64'sd1 <<< IW) - 64'sd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIZE,
    S_READ_A,
    S_READ_B,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t        r_state;
  logic          r_mode_tb;
  logic          r_sat_en;
  logic          r_size_bad;
  logic [1:0]    r_cnt;
  logic [IW-1:0] r_ra;
  logic [IW-1:0] r_ca;
  logic [IW-1:0] r_rb;
  logic [IW-1:0] r_cb;
  logic [IW-1:0] r_r;
  logic [IW-1:0] r_c;
  logic [IW-1:0] r_k;
  logic [DW-1:0] r_a;
  logic [AW-1:0] r_acc;
  logic          r_read;
  logic          r_write;
  logic [1:0]    r_sel;
  logic [IW-1:0] r_i;
  logic [IW-1:0] r_j;
  logic [OW-1:0] r_wdata;
  logic          r_busy;
  logic          r_finish;
  logic          r_err;
  logic          r_ovf;

  logic signed [63:0] w_rd_ext;
  logic               w_size_bad;
  logic [IW-1:0]      w_rd_idx;
  logic [IW-1:0]      w_rb_final;
  logic               w_dim_bad;
  logic [2*DW-1:0]    w_a_ext;
  logic [2*DW-1:0]    w_b_ext;
  logic [2*DW-1:0]    w_prod;
  logic [AW-1:0]      w_acc_next;
  logic [AW-OW:0]     w_top;
  logic               w_out_ovf;
  logic [OW-1:0]      w_conv;
  logic               w_k_last;
  logic               w_c_last;
  logic               w_r_last;
  logic [IW-1:0]      w_k_inc;

  // A size word is valid only when it is a strictly positive value no larger than MAX_DIM.
  assign w_rd_ext   = {{(64-DW){read_data[DW-1]}}, read_data};
  assign w_size_bad = (w_rd_ext <= 64'sd0) || (w_rd_ext > MAX_DIM);
  assign w_rd_idx   = read_data[IW-1:0];

  // The fourth size word is still on the bus when the dimension check is made.
  assign w_rb_final = r_mode_tb ? w_rd_idx : r_rb;
  assign w_dim_bad  = r_size_bad | w_size_bad | (r_ca != w_rb_final);

  // Exact signed product of the held A element and the incoming B element.
  assign w_a_ext    = {{DW{r_a[DW-1]}}, r_a};
  assign w_b_ext    = {{DW{read_data[DW-1]}}, read_data};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_acc_next = r_acc + {{IW{w_prod[2*DW-1]}}, w_prod};

  // Result fits in OW bits only when all bits above the OW sign bit copy it.
  assign w_top      = w_acc_next[AW-1:OW-1];
  assign w_out_ovf  = !((&w_top) || !(|w_top));
  assign w_conv     = (w_out_ovf && r_sat_en)
                      ? (w_acc_next[AW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}})
                      : w_acc_next[OW-1:0];

  assign w_k_last   = (r_k == r_ca - 1'b1);
  assign w_c_last   = (r_c == r_cb - 1'b1);
  assign w_r_last   = (r_r == r_ra - 1'b1);
  assign w_k_inc    = r_k + 1'b1;

  // Job sequencer: size fetch, dot-product loop and result write-back, all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mode_tb  <= 1'b0;
      r_sat_en   <= 1'b0;
      r_size_bad <= 1'b0;
      r_cnt      <= '0;
      r_ra       <= '0;
      r_ca       <= '0;
      r_rb       <= '0;
      r_cb       <= '0;
      r_r        <= '0;
      r_c        <= '0;
      r_k        <= '0;
      r_a        <= '0;
      r_acc      <= '0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_sel      <= 2'b00;
      r_i        <= '0;
      r_j        <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_finish   <= 1'b0;
      r_err      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_mode_tb  <= mode_tb;
            r_sat_en   <= sat_en;
            r_finish   <= 1'b0;
            r_err      <= 1'b0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_size_bad <= 1'b0;
            r_read     <= 1'b1;
            r_sel      <= 2'b00;
            r_i        <= '0;
            r_j        <= '0;
            r_state    <= S_SIZE;
          end
        end
        S_SIZE: begin
          if (read_valid) begin
            if (r_cnt == 2'd0) r_ra <= w_rd_idx;
            if (r_cnt == 2'd1) r_ca <= w_rd_idx;
            if (r_cnt == 2'd2) begin
              if (r_mode_tb) r_cb <= w_rd_idx;
              else           r_rb <= w_rd_idx;
            end
            if (r_cnt == 2'd3) begin
              if (r_mode_tb) r_rb <= w_rd_idx;
              else           r_cb <= w_rd_idx;
              if (w_dim_bad) begin
                r_read  <= 1'b0;
                r_busy  <= 1'b0;
                r_err   <= 1'b1;
                r_state <= S_ERR;
              end else begin
                r_sel   <= 2'b01;
                r_i     <= '0;
                r_j     <= '0;
                r_r     <= '0;
                r_c     <= '0;
                r_k     <= '0;
                r_acc   <= '0;
                r_state <= S_READ_A;
              end
            end else begin
              r_size_bad <= r_size_bad | w_size_bad;
              r_cnt      <= r_cnt + 2'd1;
              r_i        <= r_i + 1'b1;
            end
          end
        end
        S_READ_A: begin
          if (read_valid) begin
            r_a     <= read_data;
            r_sel   <= 2'b10;
            r_i     <= r_mode_tb ? r_c : r_k;
            r_j     <= r_mode_tb ? r_k : r_c;
            r_state <= S_READ_B;
          end
        end
        S_READ_B: begin
          if (read_valid) begin
            r_acc <= w_acc_next;
            if (w_k_last) begin
              r_read  <= 1'b0;
              r_write <= 1'b1;
              r_sel   <= 2'b11;
              r_i     <= r_r;
              r_j     <= r_c;
              r_wdata <= w_conv;
              if (w_out_ovf) r_ovf <= 1'b1;
              r_state <= S_WRITE;
            end else begin
              r_k     <= w_k_inc;
              r_sel   <= 2'b01;
              r_i     <= r_r;
              r_j     <= w_k_inc;
              r_state <= S_READ_A;
            end
          end
        end
        S_WRITE: begin
          if (write_ready) begin
            r_write <= 1'b0;
            r_acc   <= '0;
            r_k     <= '0;
            if (w_c_last && w_r_last) begin
              r_busy   <= 1'b0;
              r_finish <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_read <= 1'b1;
              r_sel  <= 2'b01;
              r_j    <= '0;
              if (w_c_last) begin
                r_r <= r_r + 1'b1;
                r_c <= '0;
                r_i <= r_r + 1'b1;
              end else begin
                r_c <= r_c + 1'b1;
                r_i <= r_r;
              end
              r_state <= S_READ_A;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign read       = r_read;
  assign write      = r_write;
  assign sel        = r_sel;
  assign i          = r_i;
  assign j          = r_j;
  assign write_data = r_wdata;
  assign busy       = r_busy;
  assign finish     = r_finish;
  assign err        = r_err;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_mm_engine.sv
// tb_mm_engine: directed bench for mm_engine with a small memory model per instance,
// a wide (20/40-bit) engine with optional random handshake delays and a narrow
// (8/16-bit) engine for saturation and wrap behaviour.
module tb_mm_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic        modeTb;
  logic        satEn;
  logic        read;
  logic        write;
  logic [1:0]  sel;
  logic [7:0]  i;
  logic [7:0]  j;
  logic [19:0] readData;
  logic        readValid;
  logic        writeReady;
  logic [39:0] writeData;
  logic        busy;
  logic        finish;
  logic        err;
  logic        ovf;

  logic        start2;
  logic        satEn2;
  logic        read2;
  logic        write2;
  logic [1:0]  sel2;
  logic [7:0]  i2;
  logic [7:0]  j2;
  logic [7:0]  readData2;
  logic        readValid2;
  logic        writeReady2;
  logic [15:0] writeData2;
  logic        busy2;
  logic        finish2;
  logic        err2;
  logic        ovf2;

  logic signed [19:0] memSize [0:3];
  logic signed [19:0] memA [0:3][0:3];
  logic signed [19:0] memB [0:3][0:3];
  logic signed [7:0]  mem2Size [0:3];
  logic signed [7:0]  mem2A [0:3][0:3];
  logic signed [7:0]  mem2B [0:3][0:3];

  logic        zeroWait = 1'b1;
  int          rdCount = 0;
  int          rdTarget = 0;
  int          wrCount = 0;
  int          wrTarget = 0;

  logic [7:0]  wrI[$];
  logic [7:0]  wrJ[$];
  logic [39:0] wrD[$];
  logic [15:0] wr2D[$];
  logic [15:0] bAddr[$];

  int          wrPulses = 0;
  int          bothHigh = 0;
  int          unstable = 0;
  logic        rdPending = 1'b0;
  logic        wrPending = 1'b0;
  logic [17:0] rdHeld = '0;
  logic [57:0] wrHeld = '0;

  int          total = 0;
  int          bad = 0;

  mm_engine #(.DW(20), .OW(40), .IW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_tb(modeTb), .sat_en(satEn),
    .read(read), .write(write), .sel(sel), .i(i), .j(j),
    .read_data(readData), .read_valid(readValid), .write_ready(writeReady),
    .write_data(writeData), .busy(busy), .finish(finish), .err(err), .ovf(ovf)
  );

  mm_engine #(.DW(8), .OW(16), .IW(8)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .mode_tb(1'b0), .sat_en(satEn2),
    .read(read2), .write(write2), .sel(sel2), .i(i2), .j(j2),
    .read_data(readData2), .read_valid(readValid2), .write_ready(writeReady2),
    .write_data(writeData2), .busy(busy2), .finish(finish2), .err(err2), .ovf(ovf2)
  );

  // Memory read port for the wide engine, addressed by region and (i, j).
  always_comb begin
    readData = '0;
    case (sel)
      2'b00:   readData = memSize[i[1:0]];
      2'b01:   readData = memA[i[1:0]][j[1:0]];
      2'b10:   readData = memB[i[1:0]][j[1:0]];
      default: readData = '0;
    endcase
  end

  // Memory read port for the narrow engine; it always answers immediately.
  always_comb begin
    readData2 = '0;
    case (sel2)
      2'b00:   readData2 = mem2Size[i2[1:0]];
      2'b01:   readData2 = mem2A[i2[1:0]][j2[1:0]];
      2'b10:   readData2 = mem2B[i2[1:0]][j2[1:0]];
      default: readData2 = '0;
    endcase
  end

  assign readValid   = zeroWait | (rdCount >= rdTarget);
  assign writeReady  = zeroWait | (wrCount >= wrTarget);
  assign readValid2  = 1'b1;
  assign writeReady2 = 1'b1;

  // Random 0-3 cycle completion delay per request when zero-wait mode is off.
  always @(posedge clk) begin
    if (read && readValid) begin
      rdCount  <= 0;
      rdTarget <= int'($urandom_range(0, 3));
    end else if (read) begin
      rdCount <= rdCount + 1;
    end
    if (write && writeReady) begin
      wrCount  <= 0;
      wrTarget <= int'($urandom_range(0, 3));
    end else if (write) begin
      wrCount <= wrCount + 1;
    end
  end

  // Bus observer: records accepted writes and B reads, and watches request stability.
  always @(posedge clk) begin
    if (!reset) begin
      if (write && writeReady) begin
        wrI.push_back(i);
        wrJ.push_back(j);
        wrD.push_back(writeData);
      end
      if (read && readValid && sel == 2'b10) bAddr.push_back({i, j});
      if (write) wrPulses <= wrPulses + 1;
      if (read && write) bothHigh <= bothHigh + 1;
      if (rdPending && (read !== 1'b1 || {sel, i, j} !== rdHeld)) unstable <= unstable + 1;
      if (wrPending && (write !== 1'b1 || {sel, i, j, writeData} !== wrHeld)) unstable <= unstable + 1;
      if (write2) wr2D.push_back(writeData2);
    end
    rdPending <= !reset && read && !readValid;
    rdHeld    <= {sel, i, j};
    wrPending <= !reset && write && !writeReady;
    wrHeld    <= {sel, i, j, writeData};
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Launches one job on engine 1 or 2 and waits (bounded) until it finishes or errors.
  task automatic applyStimulus(input int which, input logic mtb, input logic sat, output int cycles);
    @(negedge clk);
    if (which == 1) begin
      start  = 1'b1;
      modeTb = mtb;
      satEn  = sat;
    end else begin
      start2 = 1'b1;
      satEn2 = sat;
    end
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
    cycles = 0;
    while (cycles < 2000 && !((which == 1) ? (finish || err) : (finish2 || err2))) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic clearMem();
    for (int a = 0; a < 4; a++) begin
      memSize[a]  = '0;
      mem2Size[a] = '0;
      for (int b = 0; b < 4; b++) begin
        memA[a][b]  = '0;
        memB[a][b]  = '0;
        mem2A[a][b] = '0;
        mem2B[a][b] = '0;
      end
    end
  endtask

  task automatic clearLogs();
    wrI.delete();
    wrJ.delete();
    wrD.delete();
    wr2D.delete();
    bAddr.delete();
  endtask

  // A=[[1,2],[3,4]], B=[[5,6],[7,8]], optionally with B stored as B^T.
  task automatic loadSquare(input logic transposed);
    clearMem();
    for (int a = 0; a < 4; a++) memSize[a] = 20'sd2;
    memA[0][0] = 20'sd1; memA[0][1] = 20'sd2;
    memA[1][0] = 20'sd3; memA[1][1] = 20'sd4;
    memB[0][0] = 20'sd5; memB[1][1] = 20'sd8;
    if (transposed) begin
      memB[0][1] = 20'sd7; memB[1][0] = 20'sd6;
    end else begin
      memB[0][1] = 20'sd6; memB[1][0] = 20'sd7;
    end
  endtask

  task automatic checkSquare(input string name);
    int expC[4];
    expC = '{19, 22, 43, 50};
    checkOutput({name, " finish"}, 64'(finish), 64'd1);
    checkOutput({name, " count"}, 64'(wrD.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < wrD.size()) begin
        checkOutput($sformatf("%s c%0d value", name, k), 64'($signed(wrD[k])), 64'(expC[k]));
        checkOutput($sformatf("%s c%0d addr", name, k), 64'({wrI[k], wrJ[k]}), 64'({8'(k / 2), 8'(k % 2)}));
      end
    end
    checkOutput({name, " busy"}, 64'(busy), 64'd0);
    checkOutput({name, " ovf"}, 64'(ovf), 64'd0);
  endtask

  initial begin
    int cycles;
    int pulsesBefore;
    int n;
    int reqSeen;

    reset  = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    modeTb = 1'b0;
    satEn  = 1'b0;
    satEn2 = 1'b0;
    clearMem();
    clearLogs();
    repeat (3) @(negedge clk);
    checkOutput("reset outputs", {read, write, busy, finish, err, ovf, sel, i, j, writeData}, 64'd0);
    checkOutput("reset outputs dut2", 64'({read2, write2, busy2, finish2, err2, ovf2, sel2, i2, j2, writeData2}), 64'd0);
    reset = 1'b0;

    $display("[TB] 2x2 product, zero-wait memory");
    loadSquare(1'b0);
    clearLogs();
    applyStimulus(1, 1'b0, 1'b0, cycles);
    checkOutput("square cycles", 64'(cycles), 64'd24);
    checkSquare("square");

    $display("[TB] 1x3 by 3x2 with negatives");
    clearMem();
    memSize[0] = 20'sd1; memSize[1] = 20'sd3; memSize[2] = 20'sd3; memSize[3] = 20'sd2;
    memA[0][0] = -20'sd1; memA[0][1] = 20'sd2; memA[0][2] = -20'sd3;
    memB[0][0] = 20'sd4;  memB[0][1] = 20'sd0;
    memB[1][0] = -20'sd5; memB[1][1] = 20'sd1;
    memB[2][0] = 20'sd6;  memB[2][1] = -20'sd2;
    clearLogs();
    applyStimulus(1, 1'b0, 1'b0, cycles);
    checkOutput("neg done", 64'(finish), 64'd1);
    checkOutput("neg count", 64'(wrD.size()), 64'd2);
    checkOutput("neg c00", 64'($signed(wrD[0])), 64'(-32));
    checkOutput("neg c01", 64'($signed(wrD[1])), 64'd8);
    checkOutput("neg c01 addr", 64'({wrI[1], wrJ[1]}), 64'(16'h0001));
    checkOutput("neg ovf", 64'(ovf), 64'd0);

    $display("[TB] transpose mode");
    loadSquare(1'b1);
    clearLogs();
    applyStimulus(1, 1'b1, 1'b0, cycles);
    checkOutput("trans cycles", 64'(cycles), 64'd24);
    checkSquare("trans");
    checkOutput("trans b0 addr", 64'(bAddr[0]), 64'(16'h0000));
    checkOutput("trans b1 addr", 64'(bAddr[1]), 64'(16'h0001));
    checkOutput("trans b2 addr", 64'(bAddr[2]), 64'(16'h0100));
    checkOutput("trans b3 addr", 64'(bAddr[3]), 64'(16'h0101));

    $display("[TB] narrow engine saturation and wrap");
    clearMem();
    mem2Size[0] = 8'sd1; mem2Size[1] = 8'sd4; mem2Size[2] = 8'sd4; mem2Size[3] = 8'sd1;
    for (int k = 0; k < 4; k++) begin
      mem2A[0][k] = 8'sd127;
      mem2B[k][0] = 8'sd127;
    end
    clearLogs();
    applyStimulus(2, 1'b0, 1'b1, cycles);
    checkOutput("sat done", 64'(finish2), 64'd1);
    checkOutput("sat count", 64'(wr2D.size()), 64'd1);
    checkOutput("sat value", 64'(wr2D[0]), 64'(16'h7FFF));
    checkOutput("sat ovf", 64'(ovf2), 64'd1);
    clearLogs();
    applyStimulus(2, 1'b0, 1'b0, cycles);
    checkOutput("wrap done", 64'(finish2), 64'd1);
    checkOutput("wrap value", 64'(wr2D[0]), 64'(16'hFC04));
    checkOutput("wrap ovf", 64'(ovf2), 64'd1);

    $display("[TB] dimension errors");
    clearMem();
    memSize[0] = 20'sd2; memSize[1] = 20'sd3; memSize[2] = 20'sd2; memSize[3] = 20'sd2;
    pulsesBefore = wrPulses;
    applyStimulus(1, 1'b0, 1'b0, cycles);
    checkOutput("mismatch err", 64'(err), 64'd1);
    checkOutput("mismatch busy", 64'(busy), 64'd0);
    checkOutput("mismatch finish", 64'(finish), 64'd0);
    checkOutput("mismatch cycles", 64'(cycles), 64'd4);
    checkOutput("mismatch writes", 64'(wrPulses - pulsesBefore), 64'd0);
    memSize[0] = 20'sd0; memSize[1] = 20'sd2;
    pulsesBefore = wrPulses;
    applyStimulus(1, 1'b0, 1'b0, cycles);
    checkOutput("zero-ra err", 64'(err), 64'd1);
    checkOutput("zero-ra busy", 64'(busy), 64'd0);
    checkOutput("zero-ra writes", 64'(wrPulses - pulsesBefore), 64'd0);
    loadSquare(1'b0);
    clearLogs();
    applyStimulus(1, 1'b0, 1'b0, cycles);
    checkOutput("after-err err", 64'(err), 64'd0);
    checkSquare("after-err");

    $display("[TB] random delays and reset during second write");
    zeroWait = 1'b0;
    loadSquare(1'b0);
    clearLogs();
    @(negedge clk);
    start  = 1'b1;
    modeTb = 1'b0;
    satEn  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(write && wrD.size() == 1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach second write", 64'(n < 2000), 64'd1);
    checkOutput("delayed c00", 64'($signed(wrD[0])), 64'd19);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midjob reset outputs", {read, write, busy, finish, err, ovf, sel, i, j, writeData}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    reqSeen = 0;
    repeat (6) begin
      @(negedge clk);
      if (read || write || busy) reqSeen++;
    end
    checkOutput("idle after reset", 64'(reqSeen), 64'd0);
    clearLogs();
    applyStimulus(1, 1'b0, 1'b0, cycles);
    checkOutput("delayed done in time", 64'(cycles < 2000), 64'd1);
    checkSquare("delayed");
    zeroWait = 1'b1;

    checkOutput("requests stable", 64'(unstable), 64'd0);
    checkOutput("read and write exclusive", 64'(bothHigh), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
